conv1_stream_loader: RTL

CONV1_STREAM_LOADER -- requirements
Module: conv1_stream_loader

---
 rtl/conv1_stream_loader_pkg.sv | 20 ++
 rtl/conv1_addr_gen.sv | 39 +++
 rtl/conv1_stream_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/conv1_stream_loader_pkg.sv
// Shared constants and FSM encoding for the conv1 stream loader.
// Default sizes describe a 28x28 single-channel image feeding a 2-filter 5x5 conv layer.
package conv1_stream_loader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NP         = 784;
    localparam int DEFAULT_NW         = 50;
    localparam int DEFAULT_NB         = 2;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        IMG,
        WGT,
        BIAS,
        DRAIN,
        WAIT_FIN
    } state_t;

endpackage

// File: rtl/conv1_addr_gen.sv
// Source-memory address counter with phase-boundary decode for the conv1 loader.
// The counter saturates on the last word instead of wrapping.
module conv1_addr_gen
    import conv1_stream_loader_pkg::*;
#(
    parameter int NP         = DEFAULT_NP,
    parameter int NW         = DEFAULT_NW,
    parameter int NB         = DEFAULT_NB,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  img_last,
    output logic                  wgt_last,
    output logic                  all_last
);

    localparam logic [ADDR_WIDTH-1:0] IMG_END = ADDR_WIDTH'(NP - 1);
    localparam logic [ADDR_WIDTH-1:0] WGT_END = ADDR_WIDTH'(NP + NW - 1);
    localparam logic [ADDR_WIDTH-1:0] ALL_END = ADDR_WIDTH'(NP + NW + NB - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (advance && !all_last) begin
            addr <= addr + 1'b1;
        end
    end

    assign img_last = (addr == IMG_END);
    assign wgt_last = (addr == WGT_END);
    assign all_last = (addr == ALL_END);

endmodule

// File: rtl/conv1_stream_loader.sv
// Streams pixels, weights and biases from a flat source memory into the conv1 layer.
// Optional feature: define CONV1_LOADER_CHECKSUM_EN to add a 32-bit running checksum output.
module conv1_stream_loader
    import conv1_stream_loader_pkg::*;
#(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 2,
    parameter int IN_IMG_SIZE  = 28,
    parameter int KERNEL_SIZE  = 5,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         mem_rd_en,
    output logic        [ADDR_WIDTH-1:0] mem_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_rdata,
    output logic                         start_conv1,
    output logic                         data_valid,
    output logic signed [DATA_WIDTH-1:0] partial_image_in,
    output logic signed [DATA_WIDTH-1:0] partial_weights_in,
    output logic signed [DATA_WIDTH-1:0] partial_biases_in,
    input  logic                         finish_conv1
`ifdef CONV1_LOADER_CHECKSUM_EN
    ,
    output logic                  [31:0] checksum
`endif
);

    localparam int NP = IN_IMG_SIZE * IN_IMG_SIZE * IN_CHANNELS;
    localparam int NW = KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS;
    localparam int NB = OUT_CHANNELS;

    state_t state;
    logic   accept;
    logic   streaming;
    logic   img_last;
    logic   wgt_last;
    logic   all_last;

    assign accept    = (state == IDLE) && start;
    assign streaming = (state == IMG) || (state == WGT) || (state == BIAS);

    conv1_addr_gen #(
        .NP        (NP),
        .NW        (NW),
        .NB        (NB),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .advance (streaming),
        .addr    (mem_addr),
        .img_last(img_last),
        .wgt_last(wgt_last),
        .all_last(all_last)
    );

    // The word read this cycle belongs to the current phase state, so it is steered by state directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            mem_rd_en          <= 1'b0;
            start_conv1        <= 1'b0;
            data_valid         <= 1'b0;
            partial_image_in   <= '0;
            partial_weights_in <= '0;
            partial_biases_in  <= '0;
        end else begin
            done       <= 1'b0;
            data_valid <= mem_rd_en;
            if (finish_conv1 && (state != WAIT_FIN)) begin
                err <= 1'b1;
            end
            if (mem_rd_en) begin
                case (state)
                    IMG:     partial_image_in   <= mem_rdata;
                    WGT:     partial_weights_in <= mem_rdata;
                    BIAS:    partial_biases_in  <= mem_rdata;
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PULSE;
                        start_conv1 <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                PULSE: begin
                    start_conv1 <= 1'b0;
                    mem_rd_en   <= 1'b1;
                    state       <= IMG;
                end
                IMG: begin
                    if (img_last) state <= WGT;
                end
                WGT: begin
                    if (wgt_last) state <= BIAS;
                end
                BIAS: begin
                    if (all_last) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (finish_conv1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV1_LOADER_CHECKSUM_EN
    logic [31:0] rdata_ext;
    assign rdata_ext = {{(32 - DATA_WIDTH){mem_rdata[DATA_WIDTH-1]}}, mem_rdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (mem_rd_en) begin
            checksum <= checksum + rdata_ext;
        end
    end
`endif

endmodule
